i2s_capture: RTL and testbench
==============================

Name: i2s_capture

Overview:
- I2S receiver stage that feeds the audio engine's input sample buffer.
- Oversamples external sck/ws/sd in the `ck` domain and deserialises the MSB-aligned WIDTH-bit left/right words.
- Writes each word to a circular buffer at {frame, chan}. On each completed stereo frame it advances a frame pointer and pulses a strobe, so the DSP program can start on fresh data.

Parameters:
- WIDTH, 16: captured sample bits per channel, taken as the first WIDTH bits after the MSB slot.
- SLOT_BITS, 32: maximum sck periods per ws half-frame. The bit counter saturates here.
- ADDR_W, 8: log2 of buffer depth in stereo frames.

Ports:
- ck  in  1: system clock, sole clock.
- rst  in  1: asynchronous, active-high reset.
- en  in  1: capture enable.
- clr_err  in  1: single-cycle clear of err_short.
- sck  in  1: I2S bit clock, asynchronous.
- ws  in  1: I2S word select, asynchronous; 0 = left/chan 0, 1 = right/chan 1.
- sd  in  1: I2S serial data, asynchronous.
- wr_en  out  1: one-cycle buffer write strobe.
- wr_addr  out  ADDR_W+1: {frame_ptr, chan}.
- wr_data  out  WIDTH: two's-complement sample, raw, no conversion.
- frame_ptr  out  ADDR_W: index of the frame currently being filled.
- frame_strobe  out  1: one-cycle pulse when a stereo frame completes.
- err_short  out  1: sticky flag; a half-frame ended before WIDTH bits were captured.

Behaviour:
- Reset values: all outputs 0, bit counter 0, synchronisers 0, state HUNT.
- Synchronisation:
  - sck, ws and sd each pass through 2 flops; a third sck flop gives rising-edge detect.
  - ws and sd are sampled on the same ck as the detected sck rise.
  - Constraint: sck high and low each last at least 3 ck cycles.
- State HUNT (entered on reset, or when en is low):
  - No writes.
  - Waits for a detected sck rise where sampled ws is 0 and the previous sampled ws was 1 (a left-word start), then goes to RUN.
- State RUN, on each sck rise (sck_rise):
  - ws change edge:
    - bit_cnt is set to 0 and chan is latched to the new ws.
    - The sd bit on this edge is the previous word's LSB and is ignored.
  - Other edges:
    - bit_cnt increments, saturating at SLOT_BITS.
    - For bit_cnt 1..WIDTH, sd is shifted into shreg, MSB first.
  - Word complete: on the edge where bit_cnt reaches WIDTH, set a pending flag. On the following ck:
    - wr_en=1;
    - wr_data=shreg;
    - wr_addr={frame_ptr, chan}.
  - Frame complete: on the ck after a chan-1 write:
    - frame_ptr increments, wrapping modulo 2^ADDR_W;
    - frame_strobe=1 for that one cycle.
  - Write-to-strobe latency: exactly 1 ck.
- Short word:
  - A ws change arriving while 0 < bit_cnt < WIDTH sets err_short.
  - The partial word is discarded (no write) and the new word starts normally.
  - A chan-1 short word does not advance frame_ptr.
- Missing left word: a right word with no preceding valid left word is still written. frame_ptr advances only on a chan-1 write.
- en deasserted mid-word:
  - Returns immediately to HUNT; the partial word is discarded.
  - frame_ptr holds; no strobe.
- rst mid-operation: all state clears asynchronously. No wr_en may be emitted in the cycle rst deasserts.
- Error flag priority: clr_err and a new short event in the same cycle leave err_short=1.
- Bit counter: never wraps, so ws stuck for a long time produces exactly one write per half-frame.

Decomposition:
- Package i2s_pkg holds:
  - default constants WIDTH/SLOT_BITS/ADDR_W;
  - state enum HUNT/RUN;
  - CHAN_L=0, CHAN_R=1.
- One natural sub-module: sync_edge. It is a 2-flop synchroniser plus rise detect, instantiated for sck; the ws and sd variants have no edge output.

Test Plan:
- Normal stereo, sck=ck/8:
  - Stimulus: en=1; send left 16'h1234 and right 16'hABCD in 32-bit slots.
  - Required: wr_en at {0,0}=1234, then {0,1}=ABCD; frame_strobe once; frame_ptr 0->1.
- Alignment:
  - Stimulus: enable mid-right-word, then send 2 full frames.
  - Required: no write before the first ws 1->0 edge; exactly 4 writes; frame_ptr=2.
- Wrap:
  - Stimulus: ADDR_W=2, 5 frames of incrementing samples.
  - Required: frame_ptr sequence 1,2,3,0,1; frame 4 left word written at wr_addr 3'b000.
- Short word:
  - Stimulus: left slot only 10 bits long.
  - Required: no left write; err_short=1 and stays set; right word still written; clr_err clears the flag.
- Disable/reset mid-word:
  - Stimulus: drop en after 8 bits of the left word; separately, pulse rst mid-word.
  - Required: no wr_en, frame_ptr unchanged; after rst, all outputs 0 and state HUNT.
- Edge values:
  - Stimulus: samples 16'h8000 and 16'h7FFF, MSB-first.
  - Required: data written bit-exact.

Source files
------------

// File: rtl/i2s_pkg.sv
// Purpose: shared constants and types for the I2S capture block.
// Contents: default geometry (sample width, slot length, buffer depth),
//           receiver state encoding and channel codes.
package i2s_pkg;

    localparam int DEF_WIDTH     = 16;   // captured bits per channel
    localparam int DEF_SLOT_BITS = 32;   // max sck periods per ws half-frame
    localparam int DEF_ADDR_W    = 8;    // log2 of buffer depth in stereo frames

    typedef enum logic {
        HUNT = 1'b0,   // waiting for a left-word start (ws 1->0)
        RUN  = 1'b1    // aligned, deserialising words
    } state_t;

    localparam logic CHAN_L = 1'b0;
    localparam logic CHAN_R = 1'b1;

endpackage

// File: rtl/sync_edge.sv
// Purpose: 2-flop synchroniser for one asynchronous input, with an optional
//          third flop giving a single-cycle rising-edge pulse.
// Ports:   ck/rst clock and async active-high reset; d async input;
//          q synchronised level; rise one-cycle pulse on a 0->1 of q (0 when EDGE=0).
module sync_edge #(
    parameter bit EDGE = 1'b1
) (
    input  logic ck,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise
);

    logic meta;

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

    generate
        if (EDGE) begin : g_edge
            logic q_d;
            always_ff @(posedge ck or posedge rst) begin
                if (rst) q_d <= 1'b0;
                else     q_d <= q;
            end
            assign rise = q & ~q_d;
        end else begin : g_no_edge
            assign rise = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/i2s_capture.sv
// Purpose: I2S receiver; oversamples sck/ws/sd in the ck domain, deserialises
//          MSB-aligned left/right words and writes them to a circular buffer
//          addressed {frame_ptr, chan}, pulsing frame_strobe per stereo frame.
// Ports:   ck/rst/en/clr_err control; sck/ws/sd raw I2S inputs; wr_en/wr_addr/
//          wr_data buffer write port; frame_ptr, frame_strobe, err_short status.
module i2s_capture import i2s_pkg::*; #(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int SLOT_BITS = DEF_SLOT_BITS,
    parameter int ADDR_W    = DEF_ADDR_W
) (
    input  logic              ck,
    input  logic              rst,
    input  logic              en,
    input  logic              clr_err,
    input  logic              sck,
    input  logic              ws,
    input  logic              sd,
    output logic              wr_en,
    output logic [ADDR_W:0]   wr_addr,
    output logic [WIDTH-1:0]  wr_data,
    output logic [ADDR_W-1:0] frame_ptr,
    output logic              frame_strobe,
    output logic              err_short
);

    localparam int CNT_W = $clog2(SLOT_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_WORD = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SLOT_BITS);

    // ------------------------------------------------------------------
    // Input synchronisers. ws and sd share the sck pipeline depth, so the
    // values seen with sck_rise were sampled on the same ck as that rise.
    // ------------------------------------------------------------------
    logic sck_rise, ws_s, sd_s;
    logic sck_lvl_unused, ws_rise_unused, sd_rise_unused;

    sync_edge #(.EDGE(1'b1)) u_sync_sck (
        .ck(ck), .rst(rst), .d(sck), .q(sck_lvl_unused), .rise(sck_rise)
    );
    sync_edge #(.EDGE(1'b0)) u_sync_ws (
        .ck(ck), .rst(rst), .d(ws), .q(ws_s), .rise(ws_rise_unused)
    );
    sync_edge #(.EDGE(1'b0)) u_sync_sd (
        .ck(ck), .rst(rst), .d(sd), .q(sd_s), .rise(sd_rise_unused)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t           state, state_nxt;
    logic             ws_prev;   // ws sampled at the previous sck rise
    logic [CNT_W-1:0] bit_cnt;
    logic             chan;
    logic [WIDTH-1:0] shreg;
    logic             pend;      // word complete, write on next ck

    logic ws_change, run_rise, start, short_evt;

    assign ws_change = (ws_s != ws_prev);
    assign run_rise  = (state == RUN) && en && sck_rise;
    assign start     = (state == HUNT) && (state_nxt == RUN);
    // A word boundary with a partially filled word; a word that has not
    // received any bit yet (bit_cnt==0) is not counted as short.
    assign short_evt = run_rise && ws_change && (bit_cnt != '0) && (bit_cnt < CNT_WORD);

    always_ff @(posedge ck or posedge rst) begin
        if (rst) state <= HUNT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            HUNT: if (en && sck_rise && !ws_s && ws_prev) state_nxt = RUN;
            RUN:  if (!en) state_nxt = HUNT;
            default: state_nxt = HUNT;
        endcase
    end

    // ------------------------------------------------------------------
    // Deserialiser, write port and frame tracking
    // ------------------------------------------------------------------
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            ws_prev      <= 1'b0;
            bit_cnt      <= '0;
            chan         <= CHAN_L;
            shreg        <= '0;
            pend         <= 1'b0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            frame_ptr    <= '0;
            frame_strobe <= 1'b0;
            err_short    <= 1'b0;
        end else begin
            wr_en        <= 1'b0;
            frame_strobe <= 1'b0;
            pend         <= 1'b0;

            if (sck_rise) ws_prev <= ws_s;

            // Frame advance follows the right-channel write by one ck, so the
            // right word lands in the same frame slot as its left partner.
            if (wr_en && (wr_addr[0] == CHAN_R)) begin
                frame_ptr    <= frame_ptr + 1'b1;
                frame_strobe <= 1'b1;
            end

            if (pend && (state == RUN) && en) begin
                wr_en   <= 1'b1;
                wr_data <= shreg;
                wr_addr <= {frame_ptr, chan};
            end

            if (start) begin
                // The start edge is itself a ws change edge: its sd is dropped.
                bit_cnt <= '0;
                chan    <= CHAN_L;
            end else if ((state == RUN) && !en) begin
                bit_cnt <= '0;
            end else if (run_rise) begin
                if (ws_change) begin
                    bit_cnt <= '0;
                    chan    <= ws_s;
                end else begin
                    // Saturating count: a stuck ws never re-reaches WIDTH.
                    if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt < CNT_WORD) shreg <= {shreg[WIDTH-2:0], sd_s};
                    if (bit_cnt == CNT_LAST) pend <= 1'b1;
                end
            end

            // A new short event wins over a simultaneous clear.
            if (short_evt)    err_short <= 1'b1;
            else if (clr_err) err_short <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i2s_capture.sv
module tb_i2s_capture;
    import i2s_pkg::*;

    logic       ck = 1'b0;
    logic       rst, en, clr_err, sck, ws, sd;
    logic       wr_en, frame_strobe, err_short;
    logic [2:0] wr_addr;
    logic [15:0] wr_data;
    logic [1:0] frame_ptr;

    int checks   = 0;
    int failures = 0;

    i2s_capture #(.WIDTH(16), .SLOT_BITS(32), .ADDR_W(2)) dut (
        .ck(ck), .rst(rst), .en(en), .clr_err(clr_err),
        .sck(sck), .ws(ws), .sd(sd),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_ptr(frame_ptr), .frame_strobe(frame_strobe), .err_short(err_short)
    );

    always #5 ck = ~ck;

    // Write / strobe recorder
    logic [2:0]  wa_q[$];
    logic [15:0] wd_q[$];
    logic [1:0]  sp_q[$];
    int          lat_q[$];
    int          cyc = 0;
    int          last_r_cyc = 0;

    always @(posedge ck) cyc <= cyc + 1;

    always @(negedge ck) begin
        if (wr_en === 1'b1) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
            if (wr_addr[0]) last_r_cyc = cyc;
        end
        if (frame_strobe === 1'b1) begin
            sp_q.push_back(frame_ptr);
            lat_q.push_back(cyc - last_r_cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        sp_q.delete();
        lat_q.delete();
    endtask

    // One sck period: 4 ck low (data/ws change), 4 ck high.
    task automatic sck_bit(input logic ws_v, input logic sd_v);
        sck = 1'b0; ws = ws_v; sd = sd_v;
        repeat (4) @(negedge ck);
        sck = 1'b1;
        repeat (4) @(negedge ck);
    endtask

    // nbits sck periods with ws=ws_v: edge 0 carries a dummy (previous LSB)
    // bit of 1, edges 1..16 carry data MSB first, the rest pad with 0.
    task automatic send_slot(input logic ws_v, input logic [15:0] data, input int nbits);
        for (int k = 0; k < nbits; k++) begin
            if (k == 0)       sck_bit(ws_v, 1'b1);
            else if (k <= 16) sck_bit(ws_v, data[16-k]);
            else              sck_bit(ws_v, 1'b0);
        end
    endtask

    task automatic do_reset();
        @(negedge ck);
        rst = 1'b1;
        repeat (3) @(negedge ck);
        rst = 1'b0;
        repeat (2) @(negedge ck);
        clear_log();
    endtask

    logic [15:0] samp;

    initial begin
        rst = 1'b1; en = 1'b0; clr_err = 1'b0; sck = 1'b0; ws = 1'b0; sd = 1'b0;
        repeat (3) @(negedge ck);

        // ---------------- reset state ----------------
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_frame_ptr", frame_ptr, 0);
        chk("rst_strobe", frame_strobe, 0);
        chk("rst_err", err_short, 0);
        chk("rst_state", dut.state, HUNT);
        rst = 1'b0;
        repeat (2) @(negedge ck);
        clear_log();

        // ---------------- normal stereo ----------------
        en = 1'b1;
        send_slot(1'b1, 16'h0000, 32);
        send_slot(1'b0, 16'h1234, 32);
        send_slot(1'b1, 16'hABCD, 32);
        repeat (6) @(negedge ck);
        chk("norm_nwr", wa_q.size(), 2);
        if (wa_q.size() == 2) begin
            chk("norm_addr0", wa_q[0], 3'b000);
            chk("norm_data0", wd_q[0], 16'h1234);
            chk("norm_addr1", wa_q[1], 3'b001);
            chk("norm_data1", wd_q[1], 16'hABCD);
        end
        chk("norm_nstrobe", sp_q.size(), 1);
        if (lat_q.size() == 1) chk("norm_latency", lat_q[0], 1);
        chk("norm_ptr", frame_ptr, 1);
        clear_log();

        // ---------------- edge values ----------------
        send_slot(1'b0, 16'h8000, 32);
        send_slot(1'b1, 16'h7FFF, 32);
        repeat (6) @(negedge ck);
        chk("edge_nwr", wa_q.size(), 2);
        if (wa_q.size() == 2) begin
            chk("edge_addr0", wa_q[0], 3'b010);
            chk("edge_data0", wd_q[0], 16'h8000);
            chk("edge_addr1", wa_q[1], 3'b011);
            chk("edge_data1", wd_q[1], 16'h7FFF);
        end
        chk("edge_ptr", frame_ptr, 2);
        clear_log();

        // ---------------- ws stuck: counter saturates, one write ----------------
        send_slot(1'b0, 16'h0F0F, 50);
        repeat (6) @(negedge ck);
        chk("stuck_nwr", wa_q.size(), 1);
        if (wa_q.size() == 1) begin
            chk("stuck_addr", wa_q[0], 3'b100);
            chk("stuck_data", wd_q[0], 16'h0F0F);
        end
        chk("stuck_nstrobe", sp_q.size(), 0);

        // ---------------- wrap (ADDR_W=2) ----------------
        do_reset();
        chk("wrap_ptr0", frame_ptr, 0);
        send_slot(1'b1, 16'h0000, 32);
        for (int f = 0; f < 5; f++) begin
            samp = 16'hA000 + 16'(2 * f);
            send_slot(1'b0, samp, 32);
            samp = 16'hA001 + 16'(2 * f);
            send_slot(1'b1, samp, 32);
        end
        repeat (6) @(negedge ck);
        chk("wrap_nwr", wa_q.size(), 10);
        chk("wrap_nstrobe", sp_q.size(), 5);
        if (sp_q.size() == 5) begin
            chk("wrap_sp0", sp_q[0], 1);
            chk("wrap_sp1", sp_q[1], 2);
            chk("wrap_sp2", sp_q[2], 3);
            chk("wrap_sp3", sp_q[3], 0);
            chk("wrap_sp4", sp_q[4], 1);
        end
        if (wa_q.size() == 10) begin
            for (int i = 0; i < 10; i++) begin
                samp = 16'hA000 + 16'(i);
                chk("wrap_addr", wa_q[i], {2'((i / 2) % 4), 1'(i % 2)});
                chk("wrap_data", wd_q[i], samp);
            end
            chk("wrap_f4_left_addr", wa_q[8], 3'b000);
        end

        // ---------------- alignment ----------------
        do_reset();
        en = 1'b0;
        send_slot(1'b1, 16'hFFFF, 12);
        en = 1'b1;
        send_slot(1'b1, 16'hFFFF, 20);
        chk("align_nwr_pre", wa_q.size(), 0);
        send_slot(1'b0, 16'h1111, 32);
        send_slot(1'b1, 16'h2222, 32);
        send_slot(1'b0, 16'h3333, 32);
        send_slot(1'b1, 16'h4444, 32);
        repeat (6) @(negedge ck);
        chk("align_nwr", wa_q.size(), 4);
        if (wa_q.size() == 4) begin
            chk("align_addr0", wa_q[0], 3'b000);
            chk("align_data0", wd_q[0], 16'h1111);
            chk("align_data3", wd_q[3], 16'h4444);
        end
        chk("align_ptr", frame_ptr, 2);

        // ---------------- short word ----------------
        do_reset();
        en = 1'b1;
        send_slot(1'b1, 16'h0000, 32);
        send_slot(1'b0, 16'h5555, 10);
        send_slot(1'b1, 16'h2468, 32);
        repeat (6) @(negedge ck);
        chk("short_nwr", wa_q.size(), 1);
        if (wa_q.size() == 1) begin
            chk("short_addr", wa_q[0], 3'b001);
            chk("short_data", wd_q[0], 16'h2468);
        end
        chk("short_err", err_short, 1);
        chk("short_ptr", frame_ptr, 1);
        repeat (20) @(negedge ck);
        chk("short_err_sticky", err_short, 1);
        clr_err = 1'b1;
        @(negedge ck);
        clr_err = 1'b0;
        chk("short_err_cleared", err_short, 0);
        clear_log();

        // ---------------- disable mid-word ----------------
        send_slot(1'b0, 16'hFFFF, 9);
        en = 1'b0;
        repeat (10) @(negedge ck);
        chk("dis_nwr", wa_q.size(), 0);
        chk("dis_nstrobe", sp_q.size(), 0);
        chk("dis_ptr", frame_ptr, 1);
        chk("dis_state", dut.state, HUNT);

        // ---------------- reset mid-word ----------------
        en = 1'b1;
        send_slot(1'b1, 16'h0000, 4);
        send_slot(1'b0, 16'hFFFF, 9);
        chk("rstmid_state_pre", dut.state, RUN);
        rst = 1'b1;
        @(negedge ck);
        chk("rstmid_ptr", frame_ptr, 0);
        chk("rstmid_wr_en", wr_en, 0);
        chk("rstmid_strobe", frame_strobe, 0);
        chk("rstmid_state", dut.state, HUNT);
        rst = 1'b0;
        @(negedge ck);
        chk("rstmid_release_wr_en", wr_en, 0);
        chk("rstmid_nwr", wa_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
